// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_BYTE_W : width of one UART data byte, common to the feeder and the UART core
//   tx_state_e  : launch-controller state encoding used by uart_tx_feeder
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// Synchronous FIFO holding bytes waiting to be launched into the UART.
//   clk, reset : system clock, asynchronous active-low reset
//   i_push     : write i_din (ignored while full)
//   i_din      : write data
//   i_pop      : advance the read pointer (ignored while empty)
//   o_head     : entry at the read pointer, valid whenever o_empty=0
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
//   o_count    : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; contents are meaningless until pointed at by a valid count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch controller in front of the UART transmitter.
// Bytes arrive through a valid/ready handshake into a FIFO; each byte is presented
// on uart_data and uart_start is held until the UART shows busy, then the controller
// waits for busy to fall before launching the next one.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   in_data     : byte to transmit
//   in_valid    : in_data is valid
//   in_ready    : FIFO can accept (not full)
//   uart_busy   : UART busy, asynchronous to clk
//   uart_start  : start request to the UART, level held until acknowledged
//   uart_data   : byte presented to the UART
//   fifo_count  : bytes stored, 0..DEPTH
//   idle        : FIFO empty and controller idle
//   timeout_err : sticky, UART never acknowledged a start within ACK_TIMEOUT cycles
//
// state | meaning
// IDLE  | waiting for a stored byte and a quiet UART; pops the head on launch
// LOAD  | one cycle of data setup before start is raised
// REQ   | uart_start high, waiting for busy (or for the acknowledge timer to expire)
// DRAIN | UART transmitting; waiting for busy to fall
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   uart_busy,
    output logic                   uart_start,
    output logic [UART_BYTE_W-1:0] uart_data,
    output logic [AW:0]            fifo_count,
    output logic                   idle,
    output logic                   timeout_err
);

    localparam int              TW        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(ACK_TIMEOUT);

    tx_state_e              r_state;
    tx_state_e              w_next;
    logic                   r_busy_meta;
    logic                   r_busy_s;
    logic [TW-1:0]          r_timer;
    logic [UART_BYTE_W-1:0] r_data;
    logic                   r_timeout_err;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_BYTE_W-1:0] w_head;
    logic [AW:0]            w_count;
    logic                   w_expire;

    sync_fifo #(
        .WIDTH (UART_BYTE_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_din   (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Two-flop synchroniser for the UART-domain busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_meta <= 1'b0;
            r_busy_s    <= 1'b0;
        end else begin
            r_busy_meta <= uart_busy;
            r_busy_s    <= r_busy_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    assign w_expire = (r_timer == TIMER_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty && !r_busy_s) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_REQ;
            ST_REQ: begin
                if (r_busy_s)      w_next = ST_DRAIN;
                else if (w_expire) w_next = ST_IDLE;
            end
            ST_DRAIN: if (!r_busy_s) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // busy_s high while idle means the UART is occupied by someone else: no launch.
    always_comb begin
        w_pop      = (r_state == ST_IDLE) && !w_empty && !r_busy_s;
        uart_start = (r_state == ST_REQ);
        idle       = (r_state == ST_IDLE) && w_empty;
    end

    // Data register only changes on a pop, so it stays stable through REQ and DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data        <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_pop) r_data <= w_head;
            if (r_state == ST_LOAD) begin
                r_timer <= '0;
            end else if (r_state == ST_REQ && !r_busy_s) begin
                if (w_expire) r_timeout_err <= 1'b1;
                else          r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign uart_data   = r_data;
    assign fifo_count  = w_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH       = 16;
    localparam int AW          = 4;
    localparam int ACK_TIMEOUT = 1023;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          uart_busy = 1'b0;
    logic          uart_start;
    logic [7:0]    uart_data;
    logic [AW:0]   fifo_count;
    logic          idle;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];   // bytes accepted by the handshake, in order
    logic [7:0] rx_q[$];    // bytes captured by the UART model, in order
    bit   force_busy = 1'b0;
    bit   uart_dead  = 1'b0;
    int   busy_cnt = 0;
    int   start_rises = 0;
    bit   prev_start = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int   data_glitch = 0;
    int   max_count = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .uart_busy   (uart_busy),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .fifo_count  (fifo_count),
        .idle        (idle),
        .timeout_err (timeout_err)
    );

    // Reference: every handshake that completes is one byte the UART must eventually see.
    always @(posedge clk) begin
        if (reset && in_valid && in_ready) exp_q.push_back(in_data);
    end

    // UART model: captures a byte when it sees start while free, then stays busy 4..12 cycles.
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) uart_busy = 1'b0;
        end else if (force_busy) begin
            uart_busy = 1'b1;
        end else begin
            uart_busy = 1'b0;
            if (uart_start && !uart_dead && reset) begin
                rx_q.push_back(uart_data);
                uart_busy = 1'b1;
                busy_cnt = int'($urandom_range(12, 4));
            end
        end
    end

    always @(negedge clk) begin
        if (uart_start && !prev_start) start_rises = start_rises + 1;
        if (uart_start && prev_start && uart_data !== prev_data) data_glitch = data_glitch + 1;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        prev_start = uart_start;
        prev_data  = uart_data;
    end

    task automatic wait_settle(output bit ok);
        int quiet = 0;
        for (int cyc = 0; cyc < 4000 && quiet < 6; cyc++) begin
            @(negedge clk);
            if (idle && !uart_busy && busy_cnt == 0) quiet++;
            else quiet = 0;
        end
        ok = (quiet >= 6);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_start !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_hold: uart_start=%b fifo_count=%0d, required 0 and 0", uart_start, fifo_count);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b idle=%b, required 1 and 1", in_ready, idle);
        end
        checks++;
        if (fifo_count !== '0 || uart_data !== 8'h00 || timeout_err !== 1'b0 || uart_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: count=%0d data=%h err=%b start=%b, required 0 00 0 0",
                     fifo_count, uart_data, timeout_err, uart_start);
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_single();
        int r0 = start_rises;
        int g0 = data_glitch;
        bit ok;
        @(negedge clk);
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (uart_start !== 1'b0) begin
            errors++;
            $display("FAIL single_lat0: uart_start=%b one cycle after push, required 0", uart_start);
        end
        @(negedge clk);
        checks++;
        if (uart_start !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: uart_start=%b in load cycle, required 0", uart_start);
        end
        @(negedge clk);
        checks++;
        if (uart_start !== 1'b1 || uart_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_start: uart_start=%b uart_data=%h two cycles after push, required 1 A5",
                     uart_start, uart_data);
        end
        wait_settle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_settle: idle=%b count=%0d, required idle", idle, fifo_count);
        end
        checks++;
        if (rx_q.size() != 1 || exp_q.size() != 1 || rx_q[0] !== 8'hA5 || exp_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: rx %0d bytes, required one byte A5", rx_q.size());
        end
        checks++;
        if (start_rises - r0 != 1 || data_glitch != g0) begin
            errors++;
            $display("FAIL single_starts: starts=%0d glitches=%0d, required 1 and 0", start_rises - r0, data_glitch - g0);
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_burst();
        int r0 = start_rises;
        int bad_ready = 0;
        int mism = 0;
        bit ok;
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            if (in_ready !== 1'b1) bad_ready++;
            in_data  = 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad_ready != 0 || fifo_count !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_full: count=%0d in_ready=%b early_not_ready=%0d, required 16 0 0",
                     fifo_count, in_ready, bad_ready);
        end
        in_data = 8'hEE;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd16 || uart_start !== 1'b0 || start_rises != r0) begin
            errors++;
            $display("FAIL burst_refuse: count=%0d start=%b starts=%0d while full and busy, required 16 0 0",
                     fifo_count, uart_start, start_rises - r0);
        end
        force_busy = 1'b0;
        wait_settle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL burst_settle: count=%0d, required drained", fifo_count);
        end
        foreach (rx_q[i]) if (rx_q[i] !== 8'(i + 1)) mism++;
        checks++;
        if (rx_q.size() != 16 || exp_q.size() != 16 || mism != 0 || start_rises - r0 != 16) begin
            errors++;
            $display("FAIL burst_order: rx=%0d exp=%0d mism=%0d starts=%0d, required 16 16 0 16",
                     rx_q.size(), exp_q.size(), mism, start_rises - r0);
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_full_stream();
        int r0 = start_rises;
        int mism = 0;
        bit ok;
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        max_count = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        force_busy = 1'b0;
        for (int i = 0; i < 120; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_settle(ok);
        checks++;
        if (!ok || max_count > DEPTH || exp_q.size() <= 16) begin
            errors++;
            $display("FAIL stream_level: settled=%b max_count=%0d accepted=%0d, required 1, <=16, >16",
                     ok, max_count, exp_q.size());
        end
        foreach (rx_q[i]) if (i < exp_q.size() && rx_q[i] !== exp_q[i]) mism++;
        checks++;
        if (rx_q.size() != exp_q.size() || mism != 0 || start_rises - r0 != exp_q.size()) begin
            errors++;
            $display("FAIL stream_order: rx=%0d mism=%0d starts=%0d, required %0d bytes in order",
                     rx_q.size(), mism, start_rises - r0, exp_q.size());
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_random();
        int r0 = start_rises;
        int g0 = data_glitch;
        int mism = 0;
        bit ok;
        for (int i = 0; i < 200; i++) begin
            in_valid = ($urandom_range(3, 0) == 0);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_settle(ok);
        foreach (rx_q[i]) if (i < exp_q.size() && rx_q[i] !== exp_q[i]) mism++;
        checks++;
        if (!ok || rx_q.size() != exp_q.size() || mism != 0 || start_rises - r0 != exp_q.size()
            || data_glitch != g0) begin
            errors++;
            $display("FAIL random_order: settled=%b rx=%0d mism=%0d starts=%0d glitches=%0d, required %0d bytes in order",
                     ok, rx_q.size(), mism, start_rises - r0, data_glitch - g0, exp_q.size());
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_timeout();
        int r0 = start_rises;
        int high = 0;
        int early_err = 0;
        bit ok;
        uart_dead = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_data  = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !uart_start; k++) @(negedge clk);
        checks++;
        if (uart_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_launch: uart_start=%b, required 1", uart_start);
        end
        while (uart_start && high < 3000) begin
            if (timeout_err !== 1'b0) early_err++;
            high++;
            @(negedge clk);
        end
        checks++;
        if (high != ACK_TIMEOUT + 1 || early_err != 0) begin
            errors++;
            $display("FAIL timeout_len: start held %0d cycles early_err=%0d, required %0d and 0",
                     high, early_err, ACK_TIMEOUT + 1);
        end
        checks++;
        if (timeout_err !== 1'b1 || uart_start !== 1'b0 || fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL timeout_flag: err=%b start=%b count=%0d, required 1 0 1",
                     timeout_err, uart_start, fifo_count);
        end
        uart_dead = 1'b0;
        wait_settle(ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h5A || start_rises - r0 != 2 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: rx=%0d starts=%0d err=%b, required one byte 5A, 2 starts, err 1",
                     rx_q.size(), start_rises - r0, timeout_err);
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_mid_reset();
        int r0;
        uart_dead = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !uart_start; k++) @(negedge clk);
        checks++;
        if (uart_start !== 1'b1 || fifo_count !== 5'd4) begin
            errors++;
            $display("FAIL midrst_pre: start=%b count=%0d, required 1 and 4", uart_start, fifo_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (uart_start !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL midrst_async: start=%b count=%0d, required 0 and 0", uart_start, fifo_count);
        end
        @(negedge clk);
        reset = 1'b1;
        uart_dead = 1'b0;
        exp_q.delete();
        rx_q.delete();
        r0 = start_rises;
        repeat (50) @(negedge clk);
        checks++;
        if (start_rises != r0 || rx_q.size() != 0 || idle !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: starts=%0d rx=%0d idle=%b err=%b, required 0 0 1 0",
                     start_rises - r0, rx_q.size(), idle, timeout_err);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_stream();
        test_random();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
